// File: rtl/alu_shift_seq.sv
// Multi-cycle rotate/shift unit: moves up to STEP bit positions per RUN cycle.
// The unit reports the last bit moved out as carry and flags a zero result.
module alu_shift_seq #(
    parameter int WIDTH = 5,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             carry,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] WIDTH_OP  = WIDTH'(WIDTH);
    localparam logic [CW-1:0]    WIDTH_CNT = CW'(WIDTH);
    localparam logic [CW-1:0]    STEP_CNT  = CW'(STEP);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [2:0] {
        OP_ROR = 3'b000,
        OP_ROL = 3'b001,
        OP_SHR = 3'b010,
        OP_SHL = 3'b011,
        OP_ASR = 3'b100
    } op_t;

    state_t             state, state_next;
    logic [2:0]         op_q;
    logic [CW-1:0]      remaining;
    logic [CW-1:0]      eff;
    logic [CW-1:0]      n;
    logic [CW-1:0]      n_minus1;
    logic [WIDTH-1:0]   b_mod;
    logic [WIDTH-1:0]   r_next;
    logic [2*WIDTH-1:0] dbl;
    logic               right_bit;
    logic               left_bit;
    logic               carry_next;
    logic               last_step;
    logic               accept;

    assign accept = start && (state != RUN);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign zero   = (r == '0);

    // Effective amount: rotates wrap modulo WIDTH, shifts saturate at WIDTH.
    always_comb begin
        b_mod = b % WIDTH_OP;
        case (op)
            OP_ROR, OP_ROL:         eff = CW'(b_mod);
            OP_SHR, OP_SHL, OP_ASR: eff = (b >= WIDTH_OP) ? WIDTH_CNT : CW'(b);
            default:                eff = '0;
        endcase
    end

    always_comb begin
        n         = (remaining > STEP_CNT) ? STEP_CNT : remaining;
        n_minus1  = n - CW'(1);
        last_step = (remaining <= STEP_CNT);
        dbl       = {r, r};
        right_bit = 1'b0;
        left_bit  = 1'b0;
        // Last bit out is r[n-1] for right moves and r[WIDTH-n] for left moves.
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (CW'(i) == n_minus1) begin
                right_bit = r[i];
                left_bit  = r[WIDTH-1-i];
            end
        end
        r_next     = r;
        carry_next = carry;
        case (op_q)
            OP_ROR: begin
                r_next     = WIDTH'(dbl >> n);
                carry_next = right_bit;
            end
            OP_ROL: begin
                r_next     = WIDTH'((dbl << n) >> WIDTH);
                carry_next = left_bit;
            end
            OP_SHR: begin
                r_next     = r >> n;
                carry_next = right_bit;
            end
            OP_SHL: begin
                r_next     = r << n;
                carry_next = left_bit;
            end
            OP_ASR: begin
                r_next     = $signed(r) >>> n;
                carry_next = right_bit;
            end
            default: begin
                r_next     = r;
                carry_next = carry;
            end
        endcase
        if (n == '0) begin
            carry_next = carry;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r         <= '0;
            carry     <= 1'b0;
            op_q      <= '0;
            remaining <= '0;
        end else if (accept) begin
            r         <= a;
            carry     <= 1'b0;
            op_q      <= op;
            remaining <= eff;
        end else if (state == RUN) begin
            r         <= r_next;
            carry     <= carry_next;
            remaining <= remaining - n;
        end
    end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Randomised and directed bench for alu_shift_seq with STEP=1 and STEP=2 instances
// sharing one stimulus stream, checked against a bit-at-a-time reference model.
module tb_alu_shift_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'b000;
    logic [4:0] a = '0;
    logic [4:0] b = '0;

    logic       busy1, done1, carry1, zero1;
    logic [4:0] r1;
    logic       busy2, done2, carry2, zero2;
    logic [4:0] r2;

    alu_shift_seq #(.WIDTH(5), .STEP(1)) u_step1 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy1), .done(done1), .r(r1), .carry(carry1), .zero(zero1)
    );

    alu_shift_seq #(.WIDTH(5), .STEP(2)) u_step2 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy2), .done(done2), .r(r2), .carry(carry2), .zero(zero2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [4:0] seen_r[2];
    logic       seen_c[2];
    logic       seen_z[2];
    int         seen_lat[2];
    int         pulses[2];
    int         busy_cnt[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: apply eff single-position moves, one bit at a time.
    function automatic void model(input logic [2:0] o, input logic [4:0] av, input logic [4:0] bv,
                                  input int step, output logic [4:0] res, output logic c,
                                  output int lat);
        int eff;
        logic [4:0] x;
        x = av;
        c = 1'b0;
        case (o)
            3'd0, 3'd1:       eff = int'(bv) % 5;
            3'd2, 3'd3, 3'd4: eff = (bv > 5) ? 5 : int'(bv);
            default:          eff = 0;
        endcase
        for (int i = 0; i < eff; i++) begin
            case (o)
                3'd0: begin c = x[0]; x = {x[0], x[4:1]}; end
                3'd1: begin c = x[4]; x = {x[3:0], x[4]}; end
                3'd2: begin c = x[0]; x = {1'b0, x[4:1]}; end
                3'd3: begin c = x[4]; x = {x[3:0], 1'b0}; end
                default: begin c = x[0]; x = {x[4], x[4:1]}; end
            endcase
        end
        res = x;
        lat = (eff == 0) ? 1 : (eff + step - 1) / step;
    endfunction

    task automatic sample(input int cyc);
        if (done1) begin
            pulses[0]++;
            if (seen_lat[0] < 0) begin
                seen_lat[0] = cyc; seen_r[0] = r1; seen_c[0] = carry1; seen_z[0] = zero1;
            end
        end
        if (done2) begin
            pulses[1]++;
            if (seen_lat[1] < 0) begin
                seen_lat[1] = cyc; seen_r[1] = r2; seen_c[1] = carry2; seen_z[1] = zero2;
            end
        end
        if (busy1) busy_cnt[0]++;
        if (busy2) busy_cnt[1]++;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [4:0] av, input logic [4:0] bv);
        logic [4:0] er[2];
        logic       ec[2];
        int         el[2];
        model(o, av, bv, 1, er[0], ec[0], el[0]);
        model(o, av, bv, 2, er[1], ec[1], el[1]);
        for (int d = 0; d < 2; d++) begin
            seen_lat[d] = -1; pulses[d] = 0; busy_cnt[d] = 0;
            seen_r[d] = 'x; seen_c[d] = 1'bx; seen_z[d] = 1'bx;
        end
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
        sample(0);
        for (int cyc = 1; cyc < 8; cyc++) begin
            @(negedge clk);
            sample(cyc);
        end
        check("s1_latency", seen_lat[0], el[0]);
        check("s1_result", seen_r[0], er[0]);
        check("s1_carry", seen_c[0], ec[0]);
        check("s1_zero", seen_z[0], er[0] == 5'd0);
        check("s1_pulses", pulses[0], 1);
        check("s1_busy_cycles", busy_cnt[0], el[0]);
        check("s1_r_held", r1, er[0]);
        check("s1_carry_held", carry1, ec[0]);
        check("s2_latency", seen_lat[1], el[1]);
        check("s2_result", seen_r[1], er[1]);
        check("s2_carry", seen_c[1], ec[1]);
        check("s2_pulses", pulses[1], 1);
        check("s2_busy_cycles", busy_cnt[1], el[1]);
        check("s2_r_held", r2, er[1]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle_done;
        repeat (2) @(negedge clk);
        check("rst_busy", busy1, 1'b0);
        check("rst_done", done1, 1'b0);
        check("rst_r", r1, 5'd0);
        check("rst_carry", carry1, 1'b0);
        check("rst_zero", zero1, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy1, 1'b0);
        check("idle_done", done1, 1'b0);

        run_op(3'b000, 5'b10110, 5'd2);
        check("ror_b2_r", seen_r[0], 5'b10101);
        check("ror_b2_c", seen_c[0], 1'b1);
        check("ror_b2_lat", seen_lat[0], 2);
        run_op(3'b001, 5'b10110, 5'd7);
        check("rol_b7_r", seen_r[0], 5'b11010);
        check("rol_b7_c", seen_c[0], 1'b0);
        check("rol_b7_lat", seen_lat[0], 2);
        run_op(3'b000, 5'b10110, 5'd5);
        check("ror_b5_r", seen_r[0], 5'b10110);
        check("ror_b5_lat", seen_lat[0], 1);
        run_op(3'b100, 5'b10010, 5'd9);
        check("asr_b9_r", seen_r[0], 5'b11111);
        check("asr_b9_c", seen_c[0], 1'b1);
        check("asr_b9_lat", seen_lat[0], 5);
        run_op(3'b010, 5'b00001, 5'd1);
        check("shr_b1_r", seen_r[0], 5'b00000);
        check("shr_b1_c", seen_c[0], 1'b1);
        check("shr_b1_z", seen_z[0], 1'b1);
        run_op(3'b000, 5'b00001, 5'd3);
        check("step2_ror_r", seen_r[1], 5'b00100);
        check("step2_ror_c", seen_c[1], 1'b0);
        check("step2_ror_lat", seen_lat[1], 2);
        run_op(3'b110, 5'b01101, 5'd3);
        check("badop_r", seen_r[0], 5'b01101);
        check("badop_c", seen_c[0], 1'b0);
        run_op(3'b011, 5'b10101, 5'd31);
        check("shl_sat_r", seen_r[0], 5'b00000);
        check("shl_sat_c", seen_c[0], 1'b1);

        // Start during RUN is ignored; start in DONE chains with no idle cycle.
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 5'b10110; b = 5'd2;
        @(negedge clk);
        op = 3'b011; a = 5'b11111; b = 5'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("b2b_first_done", done1, 1'b1);
        check("b2b_first_r", r1, 5'b10101);
        check("b2b_first_c", carry1, 1'b1);
        start = 1'b1; op = 3'b001; a = 5'b10110; b = 5'd7;
        @(negedge clk);
        start = 1'b0;
        check("b2b_done_drop", done1, 1'b0);
        check("b2b_busy", busy1, 1'b1);
        check("b2b_loaded", r1, 5'b10110);
        @(negedge clk);
        check("b2b_mid_done", done1, 1'b0);
        @(negedge clk);
        check("b2b_second_done", done1, 1'b1);
        check("b2b_second_r", r1, 5'b11010);
        check("b2b_second_c", carry1, 1'b0);
        repeat (6) @(negedge clk);

        // Reset pulse mid-RUN aborts the operation.
        start = 1'b1; op = 3'b100; a = 5'b10010; b = 5'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy1, 1'b0);
        check("abort_r", r1, 5'd0);
        check("abort_carry", carry1, 1'b0);
        check("abort_zero", zero1, 1'b1);
        check("abort_busy_s2", busy2, 1'b0);
        check("abort_r_s2", r2, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_done = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (done1 || done2) idle_done++;
        end
        check("abort_no_done", idle_done, 0);
        run_op(3'b000, 5'b10110, 5'd2);
        check("post_rst_r", seen_r[0], 5'b10101);

        for (int k = 0; k < 40; k++) begin
            logic [2:0] ro;
            logic [4:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = 5'($urandom);
            rb = 5'($urandom);
            run_op(ro, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
